// File: rtl/vga_chk_pkg.sv
// Shared types and helpers for the VGA frame checker: tracking states,
// pixel word width and the rotate-xor frame signature step.
package vga_chk_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    localparam int PIX_W = 16;

    function automatic logic [PIX_W-1:0] sig_update(input logic [PIX_W-1:0] sum,
                                                    input logic [PIX_W-1:0] pix);
        return {sum[PIX_W-2:0], sum[PIX_W-1]} ^ pix;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Normalises one sync input to active-high and flags its asserting edge,
// advancing the history only on enabled samples.
module vga_sync_edge #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_in,
    output logic act,
    output logic rise
);

    logic prev_r;

    assign act  = (sync_in == SYNC_POL);
    assign rise = en & act & ~prev_r;

    // Remember the normalised level of the last enabled sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else if (en) begin
            prev_r <= act;
        end
    end

endmodule

// File: rtl/vga_frame_checker.sv
// VGA receive-side timing checker: lock tracking, sticky sync/blanking errors
// and a per-frame signature. Optional VGA_CHK_STATS_EN adds pixel/error counters.
module vga_frame_checker
    import vga_chk_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [4:0]  vga_red,
    input  logic [5:0]  vga_green,
    input  logic [4:0]  vga_blue,
    input  logic        err_clr,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_cnt,
    output logic        h_err,
    output logic        v_err,
    output logic        blank_err
`ifdef VGA_CHK_STATS_EN
    ,
    output logic [19:0] act_pix_cnt,
    output logic [7:0]  err_cnt
`endif
);

    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_LO = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_HI = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_END    = HW'(H_TOTAL);
    localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_LO = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_HI = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_END    = VW'(V_TOTAL);

    chk_state_e       state_r, state_s;
    logic [HW-1:0]    hcnt_r, hcnt_s;
    logic [VW-1:0]    vcnt_r, vcnt_s;
    logic [PIX_W-1:0] sum_r, frame_sum_r, pix_s;
    logic [15:0]      frame_cnt_r;
    logic             locked_r, frame_done_r, h_err_r, v_err_r, blank_err_r;
    logic             h_act_s, h_edge_s, v_act_s, v_edge_s;
    logic             chk_en_s, active_s, h_fail_s, v_fail_s, b_fail_s, any_fail_s, report_s;

    vga_sync_edge #(.SYNC_POL(SYNC_POL != 0)) u_hsync (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_en),
        .sync_in (vga_hsync),
        .act     (h_act_s),
        .rise    (h_edge_s)
    );

    // vsync is only meaningful at line starts, so its history advances on hsync edges
    vga_sync_edge #(.SYNC_POL(SYNC_POL != 0)) u_vsync (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (h_edge_s),
        .sync_in (vga_vsync),
        .act     (v_act_s),
        .rise    (v_edge_s)
    );

    // Position of the current sample, timing checks and next tracking state
    always_comb begin
        pix_s = {vga_red, vga_green, vga_blue};
        if (h_edge_s) begin
            hcnt_s = '0;
        end else if (hcnt_r == H_END) begin
            hcnt_s = H_END;
        end else begin
            hcnt_s = hcnt_r + HW'(1);
        end
        if (!h_edge_s) begin
            vcnt_s = vcnt_r;
        end else if (v_edge_s) begin
            vcnt_s = '0;
        end else if (vcnt_r == V_END) begin
            vcnt_s = V_END;
        end else begin
            vcnt_s = vcnt_r + VW'(1);
        end
        active_s = (hcnt_s >= H_ACT_LO) && (hcnt_s <= H_ACT_HI) &&
                   (vcnt_s >= V_ACT_LO) && (vcnt_s <= V_ACT_HI);
        chk_en_s = pix_en && (state_r != SEARCH);
        h_fail_s = chk_en_s && ((h_edge_s && (hcnt_r != H_LAST)) ||
                                (h_act_s && (hcnt_s == H_SYNC_C)) ||
                                (!h_act_s && (hcnt_s < H_SYNC_C)) ||
                                (hcnt_s == H_END));
        v_fail_s = chk_en_s && ((v_edge_s && (vcnt_r != V_LAST)) ||
                                (h_edge_s && v_act_s && (vcnt_s == V_SYNC_C)) ||
                                (h_edge_s && (vcnt_s == V_END)));
        b_fail_s   = chk_en_s && (pix_s != 16'h0000) && !active_s;
        any_fail_s = h_fail_s || v_fail_s || b_fail_s;

        state_s  = state_r;
        report_s = 1'b0;
        if (pix_en) begin
            case (state_r)
                SEARCH: begin
                    if (v_edge_s) begin
                        state_s = TRACK;
                    end else begin
                        state_s = SEARCH;
                    end
                end
                TRACK: begin
                    if (any_fail_s) begin
                        state_s = SEARCH;
                    end else if (v_edge_s) begin
                        state_s  = LOCKED;
                        report_s = 1'b1;
                    end else begin
                        state_s = TRACK;
                    end
                end
                LOCKED: begin
                    if (any_fail_s) begin
                        state_s = SEARCH;
                    end else begin
                        state_s  = LOCKED;
                        report_s = v_edge_s;
                    end
                end
                default: state_s = SEARCH;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Counters, tracking state, running signature and frame report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= SEARCH;
            hcnt_r       <= '0;
            vcnt_r       <= '0;
            sum_r        <= '0;
            locked_r     <= 1'b0;
            frame_sum_r  <= 16'h0000;
            frame_cnt_r  <= 16'h0000;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= report_s;
            if (pix_en) begin
                state_r  <= state_s;
                hcnt_r   <= hcnt_s;
                vcnt_r   <= vcnt_s;
                locked_r <= (state_s == LOCKED);
                if (v_edge_s) begin
                    sum_r <= '0;
                end else if (active_s) begin
                    sum_r <= sig_update(sum_r, pix_s);
                end
                if (report_s) begin
                    frame_sum_r <= sum_r;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end
            end
        end
    end

    // Sticky error flags; a new failure beats a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_err_r     <= 1'b0;
            v_err_r     <= 1'b0;
            blank_err_r <= 1'b0;
        end else begin
            h_err_r     <= h_fail_s | (h_err_r & ~err_clr);
            v_err_r     <= v_fail_s | (v_err_r & ~err_clr);
            blank_err_r <= b_fail_s | (blank_err_r & ~err_clr);
        end
    end

    assign locked     = locked_r;
    assign frame_done = frame_done_r;
    assign frame_sum  = frame_sum_r;
    assign frame_cnt  = frame_cnt_r;
    assign h_err      = h_err_r;
    assign v_err      = v_err_r;
    assign blank_err  = blank_err_r;

`ifdef VGA_CHK_STATS_EN
    logic [19:0] act_acc_r, act_pix_cnt_r;
    logic [7:0]  err_cnt_r;

    // Active-pixel tally per frame and saturating count of error-driven drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_acc_r     <= 20'd0;
            act_pix_cnt_r <= 20'd0;
            err_cnt_r     <= 8'd0;
        end else begin
            if (pix_en) begin
                if (v_edge_s) begin
                    act_acc_r <= 20'd0;
                end else if (active_s) begin
                    act_acc_r <= act_acc_r + 20'd1;
                end
                if (report_s) begin
                    act_pix_cnt_r <= act_acc_r;
                end
            end
            if (any_fail_s) begin
                err_cnt_r <= err_clr ? 8'd1 : ((err_cnt_r == 8'd255) ? 8'd255 : err_cnt_r + 8'd1);
            end else if (err_clr) begin
                err_cnt_r <= 8'd0;
            end
        end
    end

    assign act_pix_cnt = act_pix_cnt_r;
    assign err_cnt     = err_cnt_r;
`endif

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker on a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1).
module tb_vga_frame_checker;

    logic        clk = 1'b0;
    logic        rst_n, pix_en, vga_hsync, vga_vsync, err_clr;
    logic [4:0]  vga_red, vga_blue;
    logic [5:0]  vga_green;
    logic        locked, frame_done, h_err, v_err, blank_err;
    logic [15:0] frame_sum, frame_cnt;
`ifdef VGA_CHK_STATS_EN
    logic [19:0] act_pix_cnt;
    logic [7:0]  err_cnt;
`endif

    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    logic toggle = 1'b0;

    vga_frame_checker #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_red    (vga_red),
        .vga_green  (vga_green),
        .vga_blue   (vga_blue),
        .err_clr    (err_clr),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .frame_cnt  (frame_cnt),
        .h_err      (h_err),
        .v_err      (v_err),
        .blank_err  (blank_err)
`ifdef VGA_CHK_STATS_EN
        ,
        .act_pix_cnt(act_pix_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every report must carry the 12-pixel signature and last exactly one clk
    always @(negedge clk) begin
        if (prev_done) check("done_width", 32'(frame_done), 32'd0);
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            check("frame_sum", 32'(frame_sum), 32'h0FFF);
        end
        prev_done <= frame_done;
    end

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_done"},   32'(frame_done), 32'd0);
        check({tag, "_sum"},    32'(frame_sum), 32'd0);
        check({tag, "_cnt"},    32'(frame_cnt), 32'd0);
        check({tag, "_herr"},   32'(h_err), 32'd0);
        check({tag, "_verr"},   32'(v_err), 32'd0);
        check({tag, "_berr"},   32'(blank_err), 32'd0);
    endtask

    task automatic drive(input logic hs_on, input logic vs_on, input logic [15:0] p);
        if (toggle) begin
            @(negedge clk);
            pix_en    = 1'b0;
            vga_hsync = hs_on;
            vga_vsync = vs_on;
            {vga_red, vga_green, vga_blue} = 16'hFFFF;
        end
        @(negedge clk);
        pix_en    = 1'b1;
        vga_hsync = ~hs_on;
        vga_vsync = ~vs_on;
        {vga_red, vga_green, vga_blue} = p;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int v, input int h_from, input int h_to, input logic vs_on, input int inj_h);
        logic [15:0] p;
        for (int h = h_from; h < h_to; h++) begin
            p = (h >= 3 && h <= 6 && v >= 2 && v <= 4) ? 16'h0001 : 16'h0000;
            if (h == inj_h) p = 16'h0001;
            drive(h < 2, vs_on, p);
        end
    endtask

    task automatic frame();
        for (int v = 0; v < 6; v++) line(v, 0, 8, v == 0, -1);
    endtask

    task automatic clear_errs();
        @(negedge clk);
        pix_en  = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic lk, input int cnt, input int dones);
        check({tag, "_locked"}, 32'(locked), 32'(lk));
        check({tag, "_cnt"},    32'(frame_cnt), 32'(cnt));
        check({tag, "_dones"},  32'(done_cnt), 32'(dones));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; err_clr = 1'b0;
        vga_hsync = 1'b1; vga_vsync = 1'b1;
        {vga_red, vga_green, vga_blue} = 16'h0000;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Clean generator: lock at 2nd vsync edge, reports 1..3
        frame(); expect_frame("f1", 1'b0, 0, 0);
        frame(); expect_frame("f2", 1'b1, 1, 1);
        check("f2_sum", 32'(frame_sum), 32'h0FFF);
        frame(); frame(); expect_frame("f4", 1'b1, 3, 3);
        check("f4_errs", 32'({h_err, v_err, blank_err}), 32'd0);

        // Short line: h_err and loss of lock on the next hsync edge
        line(0, 0, 8, 1'b1, -1);
        line(1, 0, 7, 1'b0, -1);
        drive(1'b1, 1'b0, 16'h0000);
        check("short_herr", 32'(h_err), 32'd1);
        check("short_locked", 32'(locked), 32'd0);
        check("short_cnt", 32'(frame_cnt), 32'd4);
        line(2, 1, 8, 1'b0, -1);
        for (int v = 3; v < 6; v++) line(v, 0, 8, 1'b0, -1);
        frame(); expect_frame("f6", 1'b0, 4, 4);
        frame(); expect_frame("f7", 1'b1, 5, 5);
        check("f7_herr_sticky", 32'(h_err), 32'd1);
        clear_errs();
        check("clr_herr", 32'(h_err), 32'd0);

        // vsync held for two lines
        for (int v = 0; v < 6; v++) line(v, 0, 8, v < 2, -1);
        check("vlong_verr", 32'(v_err), 32'd1);
        check("vlong_herr", 32'(h_err), 32'd0);
        expect_frame("f8", 1'b0, 6, 6);
        frame(); expect_frame("f9", 1'b0, 6, 6);
        frame(); expect_frame("f10", 1'b1, 7, 7);
        clear_errs();
        check("clr_verr", 32'(v_err), 32'd0);

        // Nonzero pixel during horizontal blanking
        line(0, 0, 8, 1'b1, -1);
        line(1, 0, 8, 1'b0, -1);
        drive(1'b1, 1'b0, 16'h0001);
        check("blank_berr", 32'(blank_err), 32'd1);
        check("blank_locked", 32'(locked), 32'd0);
        line(2, 1, 8, 1'b0, -1);
        for (int v = 3; v < 6; v++) line(v, 0, 8, 1'b0, -1);
        expect_frame("f11", 1'b0, 8, 8);
        frame(); frame(); expect_frame("f13", 1'b1, 9, 9);
        clear_errs();
        check("clr_berr", 32'(blank_err), 32'd0);

        // Strobed input: same results as the clean run, garbage between strobes
        @(negedge clk); pix_en = 1'b0; rst_n = 1'b0;
        @(negedge clk); check_zero("reset2"); rst_n = 1'b1;
        toggle = 1'b1;
        frame(); expect_frame("t1", 1'b0, 0, 9);
        frame(); expect_frame("t2", 1'b1, 1, 10);
        frame(); frame(); expect_frame("t4", 1'b1, 3, 12);
        check("t4_errs", 32'({h_err, v_err, blank_err}), 32'd0);
        toggle = 1'b0;

        // Asynchronous reset in the middle of a frame
        for (int v = 0; v < 3; v++) line(v, 0, 8, v == 0, -1);
        check("pre_rst_cnt", 32'(frame_cnt), 32'd4);
        #2; rst_n = 1'b0; pix_en = 1'b0;
        #1; check_zero("midrst");
        @(negedge clk); rst_n = 1'b1;
        for (int v = 3; v < 6; v++) line(v, 0, 8, 1'b0, -1);
        expect_frame("r0", 1'b0, 0, 13);
        frame(); expect_frame("r1", 1'b0, 0, 13);
        frame(); expect_frame("r2", 1'b1, 1, 14);

        @(negedge clk); pix_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
